hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined ARM core.
- Replaces the raw match-vector scheme: it tracks its own destination-register scoreboard for Execute and FWD_STAGES later stages (Memory, Writeback, and more if the pipe grows).
- Drives forward selects, stall_f/stall_d/flush_d/flush_e directly.
- Adds load-use stalls, branch flush priority and multi-cycle Execute ops (e.g. multiply) that hold the pipe for MC_LAT cycles.

---
 rtl/hazard_pkg.sv | 43 ++++
 rtl/hazard_scoreboard_fwd_select.sv | 35 +++
 rtl/hazard_scoreboard.sv | 154 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard/forwarding
//               scoreboard: scoreboard entry layouts, forward-select
//               encoding and the select-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Register addresses are stored zero-extended to this width so one
    // entry type serves every REG_AW up to this size.
    localparam int SB_WA_MAX = 8;

    // Execute-stage entry.
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [SB_WA_MAX-1:0] wa;
        logic                 load;
        logic                 mc;
    } sb_entry_t;

    // Post-Execute stage entry: only what forwarding needs.
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [SB_WA_MAX-1:0] wa;
    } stage_entry_t;

    // Forward-select encoding. Memory is encoded as FWD_STAGES, which is
    // FWD_MEM_DEFAULT with the default pipe depth.
    localparam int FWD_RF          = 0;
    localparam int FWD_WB          = 1;
    localparam int FWD_MEM_DEFAULT = 2;

    // Width of one port's forward select.
    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Combinational priority scan of the post-Execute stages for
//               one Execute read port. The youngest matching writer wins.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int SW         = 2
) (
    input  logic                            i_e_valid,
    input  logic                            i_ra_used,
    input  logic [SB_WA_MAX-1:0]            i_ra,
    input  logic [FWD_STAGES-1:0]           i_stg_valid,
    input  logic [FWD_STAGES-1:0]           i_stg_we,
    input  logic [FWD_STAGES*SB_WA_MAX-1:0] i_stg_wa,
    output logic [SW-1:0]                   o_sel
);

    // Scan oldest to youngest so a later (younger) match overrides.
    always_comb begin
        o_sel = SW'(FWD_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (i_e_valid && i_ra_used && i_stg_valid[k] && i_stg_we[k] &&
                (i_stg_wa[k*SB_WA_MAX +: SB_WA_MAX] == i_ra)) begin
                o_sel = SW'(FWD_STAGES - k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller. Tracks destination
//               registers for Execute and FWD_STAGES later stages, drives
//               forward selects, load-use stalls, branch flushes and holds
//               the pipe for multi-cycle Execute operations.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 4,
    parameter  int NUM_RD     = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int MC_LAT     = 3,
    localparam int SW         = fwd_sel_w(FWD_STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic [NUM_RD*REG_AW-1:0] dec_ra,
    input  logic [NUM_RD-1:0]        dec_ra_used,
    input  logic                     dec_we,
    input  logic [REG_AW-1:0]        dec_wa,
    input  logic                     dec_load,
    input  logic                     dec_mc,
    input  logic                     branch_taken_e,
    output logic [NUM_RD*SW-1:0]     fwd_sel,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     flush_d,
    output logic                     flush_e,
    output logic                     busy
);

    localparam int CW = $clog2(MC_LAT) + 1;

    sb_entry_t                r_e;
    sb_entry_t                w_e_next;
    logic [NUM_RD*REG_AW-1:0] r_e_ra;
    logic [NUM_RD*REG_AW-1:0] w_e_ra_next;
    logic [NUM_RD-1:0]        r_e_ra_used;
    logic [NUM_RD-1:0]        w_e_ra_used_next;
    stage_entry_t             r_stage [FWD_STAGES];
    logic [CW-1:0]            r_cnt;

    logic                            w_busy;
    logic                            w_luse;
    logic                            w_branch;
    logic [FWD_STAGES-1:0]           w_stg_valid;
    logic [FWD_STAGES-1:0]           w_stg_we;
    logic [FWD_STAGES*SB_WA_MAX-1:0] w_stg_wa;

    assign w_busy = (r_cnt != '0);
    assign busy   = w_busy;

    // Load-use: Decode reads the register a load in Execute is producing.
    always_comb begin
        w_luse = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (dec_ra_used[i] &&
                (SB_WA_MAX'(dec_ra[i*REG_AW +: REG_AW]) == r_e.wa)) begin
                w_luse = 1'b1;
            end
        end
        w_luse = w_luse & dec_valid & r_e.valid & r_e.we & r_e.load;
    end

    // Pipe control priority: taken branch, then busy, then load-use.
    // A branch can only resolve once the Execute op has finished.
    assign w_branch = branch_taken_e & ~w_busy;
    assign flush_d  = w_branch;
    assign flush_e  = w_branch | (~w_busy & w_luse);
    assign stall_f  = ~w_branch & (w_busy | w_luse);
    assign stall_d  = ~w_branch & (w_busy | w_luse);

    // Next Execute entry: Decode fields, or a bubble when flushed/empty.
    always_comb begin
        w_e_next         = '0;
        w_e_ra_next      = '0;
        w_e_ra_used_next = '0;
        if (dec_valid && !flush_e) begin
            w_e_next.valid   = 1'b1;
            w_e_next.we      = dec_we;
            w_e_next.wa      = SB_WA_MAX'(dec_wa);
            w_e_next.load    = dec_load;
            w_e_next.mc      = dec_mc;
            w_e_ra_next      = dec_ra;
            w_e_ra_used_next = dec_ra_used;
        end
    end

    // Scoreboard state: Execute entry, post-Execute stages and the
    // multi-cycle counter. While busy, Execute holds and a bubble enters
    // stage 0 so older writers keep draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e         <= '0;
            r_e_ra      <= '0;
            r_e_ra_used <= '0;
            r_cnt       <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 1; k < FWD_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            if (w_busy) begin
                r_cnt      <= r_cnt - CW'(1);
                r_stage[0] <= '0;
            end else begin
                r_stage[0].valid <= r_e.valid;
                r_stage[0].we    <= r_e.we;
                r_stage[0].wa    <= r_e.wa;
                r_e              <= w_e_next;
                r_e_ra           <= w_e_ra_next;
                r_e_ra_used      <= w_e_ra_used_next;
                r_cnt            <= (w_e_next.valid && w_e_next.mc) ?
                                    CW'(MC_LAT - 1) : '0;
            end
        end
    end

    // Flatten stage fields for the per-port scanners.
    generate
        for (genvar k = 0; k < FWD_STAGES; k++) begin : g_stage_pack
            assign w_stg_valid[k]                        = r_stage[k].valid;
            assign w_stg_we[k]                           = r_stage[k].we;
            assign w_stg_wa[k*SB_WA_MAX +: SB_WA_MAX]    = r_stage[k].wa;
        end
    endgenerate

    // One forward-select scanner per Decode read port.
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_port
            fwd_select #(
                .FWD_STAGES (FWD_STAGES),
                .SW         (SW)
            ) u_fwd_select (
                .i_e_valid   (r_e.valid),
                .i_ra_used   (r_e_ra_used[i]),
                .i_ra        (SB_WA_MAX'(r_e_ra[i*REG_AW +: REG_AW])),
                .i_stg_valid (w_stg_valid),
                .i_stg_we    (w_stg_we),
                .i_stg_wa    (w_stg_wa),
                .o_sel       (fwd_sel[i*SW +: SW])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed, table-driven bench for hazard_scoreboard with
//               default parameters, plus an async-reset-during-busy sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       dec_valid;
    logic [7:0] dec_ra;
    logic [1:0] dec_ra_used;
    logic       dec_we;
    logic [3:0] dec_wa;
    logic       dec_load;
    logic       dec_mc;
    logic       branch_taken_e;
    logic [3:0] fwd_sel;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard u_dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_ra         (dec_ra),
        .dec_ra_used    (dec_ra_used),
        .dec_we         (dec_we),
        .dec_wa         (dec_wa),
        .dec_load       (dec_load),
        .dec_mc         (dec_mc),
        .branch_taken_e (branch_taken_e),
        .fwd_sel        (fwd_sel),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ra = {port1, port0}; used = {port1, port0}
    // efwd = {sel1, sel0}; ectl = {stall_f, stall_d, flush_d, flush_e, busy}
    typedef struct {
        logic       v;
        logic [7:0] ra;
        logic [1:0] used;
        logic       we;
        logic [3:0] wa;
        logic       ld;
        logic       mc;
        logic       br;
        logic [3:0] efwd;
        logic [4:0] ectl;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic drive(input vec_t t);
        dec_valid      = t.v;
        dec_ra         = t.ra;
        dec_ra_used    = t.used;
        dec_we         = t.we;
        dec_wa         = t.wa;
        dec_load       = t.ld;
        dec_mc         = t.mc;
        branch_taken_e = t.br;
    endtask

    task automatic check(input string name, input logic [3:0] efwd, input logic [4:0] ectl);
        logic [4:0] actl;
        actl = {stall_f, stall_d, flush_d, flush_e, busy};
        n_checks++;
        if ({fwd_sel, actl} !== {efwd, ectl}) begin
            n_fail++;
            $display("FAIL %s: got fwd_sel=%b ctl=%b, expected fwd_sel=%b ctl=%b",
                     name, fwd_sel, actl, efwd, ectl);
        end
    endtask

    vec_t idle;

    initial begin
        idle = '{1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000};

        //          v    ra      used   we   wa     ld   mc   br   efwd     ectl
        tbl[0]  = '{1'b1, 8'h32, 2'b11, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // ADD r1
        tbl[1]  = '{1'b1, 8'h31, 2'b11, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // SUB r2,r1,r3
        tbl[2]  = '{1'b1, 8'h01, 2'b01, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'b0010, 5'b00000}; // r1 from MEM
        tbl[3]  = idle; tbl[3].efwd = 4'b0001;                                              // r1 from WB
        tbl[4]  = '{1'b1, 8'h00, 2'b00, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // writer A r8
        tbl[5]  = '{1'b1, 8'h00, 2'b00, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // writer B r8
        tbl[6]  = '{1'b1, 8'h88, 2'b11, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // reads r8,r8
        tbl[7]  = idle; tbl[7].efwd = 4'b1010;                                              // youngest wins
        tbl[8]  = '{1'b1, 8'h0D, 2'b01, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000}; // LDR r4
        tbl[9]  = '{1'b1, 8'h42, 2'b11, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b11010}; // load-use
        tbl[10] = '{1'b1, 8'h42, 2'b11, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // held, 1 cycle only
        tbl[11] = idle; tbl[11].efwd = 4'b0100;                                             // port1 from WB
        tbl[12] = '{1'b1, 8'h0D, 2'b01, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000}; // LDR r4
        tbl[13] = '{1'b1, 8'h42, 2'b01, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // port1 unused
        tbl[14] = idle;                                                                     // unused never forwards
        tbl[15] = '{1'b1, 8'h32, 2'b11, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 4'b0000, 5'b00000}; // MUL r5
        tbl[16] = '{1'b1, 8'h05, 2'b01, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b11001}; // busy 1
        tbl[17] = '{1'b1, 8'h05, 2'b01, 1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 4'b0000, 5'b11001}; // busy 2, branch ignored
        tbl[18] = '{1'b1, 8'h05, 2'b01, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000}; // MUL last E cycle
        tbl[19] = idle; tbl[19].efwd = 4'b0010;                                             // r5 from MEM
        tbl[20] = '{1'b1, 8'h0D, 2'b01, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000}; // LDR r4
        tbl[21] = '{1'b1, 8'h40, 2'b10, 1'b1, 4'd13, 1'b0, 1'b0, 1'b1, 4'b0000, 5'b00110}; // branch over luse
        tbl[22] = idle;

        // Reset held: outputs must be quiet.
        reset = 1'b0;
        drive(idle);
        #3;
        check("reset_hold", 4'b0000, 5'b00000);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d", i), tbl[i].efwd, tbl[i].ectl);
            @(negedge clk);
        end

        // Async reset in the middle of a multi-cycle op (cnt = 2).
        drive(tbl[15]);
        #1;
        check("mc_issue", 4'b0000, 5'b00000);
        @(negedge clk);
        drive(tbl[16]);
        #1;
        check("mc_busy_pre_reset", 4'b0000, 5'b11001);
        reset = 1'b0;
        #1;
        check("async_reset_busy", 4'b0000, 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("after_release", 4'b0000, 5'b00000);
        @(negedge clk);
        drive(idle);
        #1;
        check("restart_empty", 4'b0000, 5'b00000);
        @(negedge clk);
        #1;
        check("restart_drain", 4'b0000, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
